serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller: accepts two WIDTH-bit operands on a start pulse and sequences a single one-bit full-adder cell, built from two half adders, over WIDTH clock cycles, one bit per cycle, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake. It sits beside the combinational adder library as the area-minimal alternative to a ripple adder.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to begin an addition; sampled on the rising edge.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when sum and carry become valid.
- sum  output  WIDTH  result of the last completed addition.
- carry  output  1  carry-out of the last completed addition.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 is accepted.
  - Accepting latches a into shift register sa and b into sb, clears the carry flip-flop and the counter, and moves to RUN.
- RUN, on each edge:
  - Full adder computes s = sa[0]^sb[0]^cf and co = majority(sa[0], sb[0], cf).
  - s shifts into the MSB of result shift register sr, and sr shifts right.
  - sa and sb shift right; cf takes co; the counter increments.
  - When the counter reaches WIDTH-1 on an edge, that edge also moves to DONE.
  - On that same edge, sum is loaded from {s, sr[WIDTH-1:1]} and carry is loaded from co.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1, the addition is accepted as in IDLE and the FSM moves to RUN. Otherwise it moves to IDLE.
- start while in RUN is ignored, with no queueing. a and b are don't-care outside the accepting edge.
- sum and carry change only on the RUN→DONE edge. They hold their value through later IDLE and RUN periods until the next completion.
- Arithmetic is unsigned. {carry, sum} = a + b, a (WIDTH+1)-bit result. The counter is $clog2(WIDTH) bits wide, minimum 1.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Numbering: cycle 0 is the cycle in which start=1 is sampled while in IDLE or DONE.
- busy is high in cycles 1..WIDTH and low otherwise.
- done is high in cycle WIDTH+1. sum and carry are valid from cycle WIDTH+1 onward.
- Latency from accepted start to done is WIDTH+1 cycles. Minimum start-to-start spacing is WIDTH+1 cycles, using a restart from DONE.
- Outputs are registered, with no combinational path from inputs to outputs.
- Reset, when rst_n=0 at an edge:
  - FSM goes to IDLE; busy=0, done=0, sum=0, carry=0.
  - Counter, cf, sa, sb and sr are cleared.
  - Reset has priority over start and over any RUN activity. An addition interrupted by reset produces no done and leaves sum=0.

## Structure
- Shared package serial_add_pkg holds:
  - the state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10, 2'b11 illegal;
  - the default width constant SA_WIDTH=8.
- The illegal state recovers to IDLE on the next edge with outputs unchanged.
- Sub-module fullAdder(a, b, cin, s, cout):
  - two existing halfAdder instances plus an OR for cout;
  - instantiated once; it is the only arithmetic in the block.
- Everything else is one clocked process plus next-state logic in serial_add_ctrl.

## Test plan
1. WIDTH=8, a=8'h00, b=8'h00, start for one cycle:
   - busy is high for 8 cycles; done is high in cycle 9;
   - sum=8'h00, carry=0.
2. a=8'hFF, b=8'h01:
   - sum=8'h00, carry=1;
   - then a=8'hA5, b=8'h5A gives sum=8'hFF, carry=0;
   - the earlier sum holds until the second done.
3. start pulsed in cycles 3 and 5 of a running a=8'h80, b=8'h80 addition:
   - the extra pulses are ignored; exactly one done;
   - sum=8'h00, carry=1; busy width stays 8.
4. Back-to-back: start held high continuously with a=8'h0F, b=8'h01:
   - done pulses every 9 cycles; each result is sum=8'h10, carry=0;
   - busy is low only in the done cycles after the first start.
5. Reset mid-operation: rst_n=0 in cycle 4 of a=8'h7F, b=8'h01:
   - next cycle busy=0, done=0, sum=0, carry=0;
   - no done follows;
   - a subsequent start with 8'h7F+8'h01 yields sum=8'h80, carry=0.
6. WIDTH=1 build, all four a/b combinations:
   - busy is high 1 cycle and done is high in cycle 2;
   - {carry, sum} = 00, 01, 01, 10.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned SA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake plus operand and result buses of the serial adder.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (output start, a, b, input busy, done, sum, carry);
  modport slave  (input start, a, b, output busy, done, sum, carry);

endinterface

// File: rtl/serial_add_ctrl_fulladder.sv
// One-bit full adder assembled from two half adders; the block's only arithmetic.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1;
  logic c1;
  logic c2;

  halfAdder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  halfAdder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  assign cout = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell over WIDTH cycles, LSB first.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cf_q, cf_d;
  logic             carry_q, carry_d;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sr_shift;

  fullAdder u_fa (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .cin (cf_q),
    .s   (fa_s),
    .cout(fa_co)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    cf_d     = cf_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    // shift form stays legal when WIDTH == 1 (no sr[WIDTH-1:1] slice)
    sr_shift = (sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          cf_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = sr_shift;
        cf_d  = fa_co;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = sr_shift;
          carry_d = fa_co;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      cf_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      cf_q    <= cf_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances, vector table plus handshake corner cases.
module tb_serial_add_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic sum;
    logic carry;
  } vec1_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] e8;
  logic [1:0] e1;
  int         total  = 0;
  int         bad    = 0;
  int         dones8 = 0;
  int         dones1 = 0;
  logic [7:0] last_sum8;
  logic       last_carry8;
  vec8_t      tv8[8];
  vec1_t      tv1[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboards: results pushed at start, popped on done.
  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      dones8++;
      if (q8.size() == 0) chk("done8_unexpected", 32'(bus8.done), 32'd0);
      else begin
        e8 = q8.pop_front();
        chk("sum8", 32'(bus8.sum), 32'(e8[7:0]));
        chk("carry8", 32'(bus8.carry), 32'(e8[8]));
      end
    end
    if (bus1.done === 1'b1) begin
      dones1++;
      if (q1.size() == 0) chk("done1_unexpected", 32'(bus1.done), 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("sum1", 32'(bus1.sum), 32'(e1[0]));
        chk("carry1", 32'(bus1.carry), 32'(e1[1]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic do_add8(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] s, input logic c);
    int busy_n;
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    q8.push_back({c, s});
    @(negedge clk);
    bus8.start = 1'b0;
    busy_n     = 0;
    for (int k = 1; k <= 8; k++) begin
      if (bus8.busy === 1'b1) busy_n++;
      chk("sum_hold", 32'(bus8.sum), 32'(last_sum8));
      chk("carry_hold", 32'(bus8.carry), 32'(last_carry8));
      @(negedge clk);
    end
    chk("busy_cycles", 32'(busy_n), 32'd8);
    chk("done_cycle", 32'(bus8.done), 32'd1);
    chk("busy_in_done", 32'(bus8.busy), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(bus8.done), 32'd0);
    chk("sum_after", 32'(bus8.sum), 32'(s));
    chk("carry_after", 32'(bus8.carry), 32'(c));
    last_sum8   = s;
    last_carry8 = c;
  endtask

  task automatic do_add1(input logic a, input logic b, input logic s, input logic c);
    bus1.start = 1'b1;
    bus1.a     = a;
    bus1.b     = b;
    q1.push_back({c, s});
    @(negedge clk);
    bus1.start = 1'b0;
    chk("w1_busy_c1", 32'(bus1.busy), 32'd1);
    chk("w1_done_c1", 32'(bus1.done), 32'd0);
    @(negedge clk);
    chk("w1_busy_c2", 32'(bus1.busy), 32'd0);
    chk("w1_done_c2", 32'(bus1.done), 32'd1);
    @(negedge clk);
    chk("w1_done_c3", 32'(bus1.done), 32'd0);
  endtask

  initial begin
    int busy_n;
    int d0;

    tv8[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tv8[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    tv8[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    tv8[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    tv8[4] = '{8'h12, 8'h34, 8'h46, 1'b0};
    tv8[5] = '{8'h0F, 8'hF1, 8'h00, 1'b1};
    tv8[6] = '{8'h3C, 8'hC3, 8'hFF, 1'b0};
    tv8[7] = '{8'hC8, 8'h64, 8'h2C, 1'b1};
    tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tv1[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tv1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tv1[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(bus8.busy), 32'd0);
    chk("rst_done8", 32'(bus8.done), 32'd0);
    chk("rst_sum8", 32'(bus8.sum), 32'd0);
    chk("rst_carry8", 32'(bus8.carry), 32'd0);
    chk("rst_busy1", 32'(bus1.busy), 32'd0);
    chk("rst_done1", 32'(bus1.done), 32'd0);
    rst_n       = 1'b1;
    last_sum8   = 8'h00;
    last_carry8 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      do_add8(tv8[i].a, tv8[i].b, tv8[i].sum, tv8[i].carry);

    // start pulses during RUN must be ignored
    bus8.start = 1'b1;
    bus8.a     = 8'h80;
    bus8.b     = 8'h80;
    q8.push_back({1'b1, 8'h00});
    d0 = dones8;
    @(negedge clk);
    busy_n = 0;
    for (int k = 1; k <= 8; k++) begin
      bus8.start = (k == 3 || k == 5);
      if (bus8.busy === 1'b1) busy_n++;
      @(negedge clk);
    end
    bus8.start = 1'b0;
    chk("ign_done_cycle", 32'(bus8.done), 32'd1);
    chk("ign_busy_cycles", 32'(busy_n), 32'd8);
    repeat (12) @(negedge clk);
    chk("ign_done_count", 32'(dones8 - d0), 32'd1);
    last_sum8   = 8'h00;
    last_carry8 = 1'b1;

    // back-to-back with start held: three additions
    for (int r = 0; r < 3; r++) q8.push_back({1'b0, 8'h10});
    bus8.start = 1'b1;
    bus8.a     = 8'h0F;
    bus8.b     = 8'h01;
    d0 = dones8;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      chk("b2b_busy", 32'(bus8.busy), 32'(c % 9 != 0));
      chk("b2b_done", 32'(bus8.done), 32'(c % 9 == 0));
      if (c == 19) bus8.start = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle_busy", 32'(bus8.busy), 32'd0);
    chk("b2b_idle_done", 32'(bus8.done), 32'd0);
    chk("b2b_done_count", 32'(dones8 - d0), 32'd3);
    chk("b2b_queue_empty", 32'(q8.size()), 32'd0);
    last_sum8   = 8'h10;
    last_carry8 = 1'b0;

    // reset in cycle 4 aborts the addition
    bus8.start = 1'b1;
    bus8.a     = 8'h7F;
    bus8.b     = 8'h01;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus8.busy), 32'd0);
    chk("mid_rst_done", 32'(bus8.done), 32'd0);
    chk("mid_rst_sum", 32'(bus8.sum), 32'd0);
    chk("mid_rst_carry", 32'(bus8.carry), 32'd0);
    rst_n = 1'b1;
    d0    = dones8;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", 32'(dones8 - d0), 32'd0);
    last_sum8   = 8'h00;
    last_carry8 = 1'b0;
    do_add8(8'h7F, 8'h01, 8'h80, 1'b0);

    for (int i = 0; i < 4; i++)
      do_add1(tv1[i].a, tv1[i].b, tv1[i].sum, tv1[i].carry);
    repeat (2) @(negedge clk);
    chk("w1_done_count", 32'(dones1), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
